// File: rtl/encoder_if.sv
// encoder_if: bundles the decimal-entry request and the BCD result side-band.
//   a         10  decimal lines, bit k = digit k
//   in_valid   1  a is sampled on this edge when high
//   b          4  registered BCD code (1111 on error)
//   out_valid  1  b/err were updated on the previous edge
//   err        1  last sampled a was illegal
// Modports: master = producer of a/in_valid (consumer of results),
//           slave  = the encoder itself.
interface encoder_if;
  logic [9:0] a;
  logic       in_valid;
  logic [3:0] b;
  logic       out_valid;
  logic       err;

  modport master (output a, output in_valid, input b, input out_valid, input err);
  modport slave  (input a, input in_valid, output b, output out_valid, output err);
endinterface

// File: rtl/encoder.sv
// encoder: decimal (10-line one-hot) to BCD encoder with registered outputs.
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  synchronous active-low reset
//   bus    encoder_if.slave (a, in_valid in; b, out_valid, err out)
// Configuration macro: ENCODER_PRIORITY_EN
//   undefined (default) - strict one-hot; multi-hot gives b=1111, err=1
//   defined             - multi-hot is priority encoded, highest bit wins
// Zero input always gives b=1111, err=1. Latency is one clock.
module encoder (
  input  logic     clk,
  input  logic     rst_n,
  encoder_if.slave bus
);

  // Returns {err, bcd}. Illegal inputs map to 1111 so b never lands on 1010-1110.
  function automatic logic [4:0] encode_dec(input logic [9:0] a_i);
    logic [4:0] res;
`ifdef ENCODER_PRIORITY_EN
    res = {1'b1, 4'b1111};
    if (a_i != 10'd0) begin
      // Ascending scan so the highest set bit overwrites lower ones.
      for (int k = 0; k < 10; k++) begin
        if (a_i[k]) begin
          res = {1'b0, 4'(k)};
        end else begin
          res = res;
        end
      end
    end else begin
      res = {1'b1, 4'b1111};
    end
`else
    case (a_i)
      10'b0000000001: res = {1'b0, 4'd0};
      10'b0000000010: res = {1'b0, 4'd1};
      10'b0000000100: res = {1'b0, 4'd2};
      10'b0000001000: res = {1'b0, 4'd3};
      10'b0000010000: res = {1'b0, 4'd4};
      10'b0000100000: res = {1'b0, 4'd5};
      10'b0001000000: res = {1'b0, 4'd6};
      10'b0010000000: res = {1'b0, 4'd7};
      10'b0100000000: res = {1'b0, 4'd8};
      10'b1000000000: res = {1'b0, 4'd9};
      default:        res = {1'b1, 4'b1111};
    endcase
`endif
    return res;
  endfunction

  logic [4:0] enc_s;
  logic [3:0] b_r;
  logic       err_r;
  logic       out_valid_r;

  // Combinational decode of the current input lines.
  always_comb begin
    enc_s = encode_dec(bus.a);
  end

  // Result registers; a is only looked at when in_valid is high, so X on a is harmless otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_r         <= 4'd0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        b_r   <= enc_s[3:0];
        err_r <= enc_s[4];
      end else begin
        b_r   <= b_r;
        err_r <= err_r;
      end
    end
  end

  assign bus.b         = b_r;
  assign bus.err       = err_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_encoder.sv
// tb_encoder: directed self-checking bench for encoder.
// Inputs are driven just after the falling edge; outputs are sampled on the
// falling edge that follows the rising edge under test.
module tb_encoder;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  encoder_if bus ();

  encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = 10'b1000000000;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if ({bus.b, bus.out_valid, bus.err} !== {4'b0000, 1'b0, 1'b0}) begin
      $display("FAIL reset: got b=%b out_valid=%b err=%b, want b=0000 out_valid=0 err=0",
               bus.b, bus.out_valid, bus.err);
    end else pass_cnt++;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Back-to-back walk: one new input every cycle, checked one cycle later.
  task automatic test_walk_one_hot();
    logic [9:0] one;
    logic [3:0] exp_tab [10];
    exp_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001};
    one = 10'd1;
    bus.in_valid = 1'b1;
    bus.a        = one;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({bus.b, bus.out_valid, bus.err} !== {exp_tab[k], 1'b1, 1'b0}) begin
        $display("FAIL walk[%0d]: got b=%b out_valid=%b err=%b, want b=%b out_valid=1 err=0",
                 k, bus.b, bus.out_valid, bus.err, exp_tab[k]);
      end else pass_cnt++;
      if (k < 9) bus.a = one << (k + 1);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    bus.in_valid = 1'b1;
    bus.a        = 10'b0000000000;
    @(negedge clk);
    total_cnt++;
    if ({bus.b, bus.out_valid, bus.err} !== {4'b1111, 1'b1, 1'b1}) begin
      $display("FAIL zero: got b=%b out_valid=%b err=%b, want b=1111 out_valid=1 err=1",
               bus.b, bus.out_valid, bus.err);
    end else pass_cnt++;
    // A legal input right after must clear err.
    bus.a = 10'b0000010000;
    @(negedge clk);
    total_cnt++;
    if ({bus.b, bus.out_valid, bus.err} !== {4'b0100, 1'b1, 1'b0}) begin
      $display("FAIL zero_recover: got b=%b out_valid=%b err=%b, want b=0100 out_valid=1 err=0",
               bus.b, bus.out_valid, bus.err);
    end else pass_cnt++;
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multi_hot();
    bus.in_valid = 1'b1;
    bus.a        = 10'b0000100100;
    @(negedge clk);
    total_cnt++;
`ifdef ENCODER_PRIORITY_EN
    if ({bus.b, bus.out_valid, bus.err} !== {4'b0101, 1'b1, 1'b0}) begin
      $display("FAIL multi_hot: got b=%b out_valid=%b err=%b, want b=0101 out_valid=1 err=0",
               bus.b, bus.out_valid, bus.err);
    end else pass_cnt++;
`else
    if ({bus.b, bus.out_valid, bus.err} !== {4'b1111, 1'b1, 1'b1}) begin
      $display("FAIL multi_hot: got b=%b out_valid=%b err=%b, want b=1111 out_valid=1 err=1",
               bus.b, bus.out_valid, bus.err);
    end else pass_cnt++;
`endif
    bus.a = 10'b1100000001;
    @(negedge clk);
    total_cnt++;
`ifdef ENCODER_PRIORITY_EN
    if ({bus.b, bus.out_valid, bus.err} !== {4'b1001, 1'b1, 1'b0}) begin
      $display("FAIL multi_hot_top: got b=%b out_valid=%b err=%b, want b=1001 out_valid=1 err=0",
               bus.b, bus.out_valid, bus.err);
    end else pass_cnt++;
`else
    if ({bus.b, bus.out_valid, bus.err} !== {4'b1111, 1'b1, 1'b1}) begin
      $display("FAIL multi_hot_top: got b=%b out_valid=%b err=%b, want b=1111 out_valid=1 err=1",
               bus.b, bus.out_valid, bus.err);
    end else pass_cnt++;
`endif
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold();
    bus.in_valid = 1'b1;
    bus.a        = 10'b0000001000;
    @(negedge clk);
    total_cnt++;
    if ({bus.b, bus.out_valid, bus.err} !== {4'b0011, 1'b1, 1'b0}) begin
      $display("FAIL hold_load: got b=%b out_valid=%b err=%b, want b=0011 out_valid=1 err=0",
               bus.b, bus.out_valid, bus.err);
    end else pass_cnt++;
    bus.in_valid = 1'b0;
    bus.a        = 10'b1000000000;
    @(negedge clk);
    total_cnt++;
    if ({bus.b, bus.out_valid, bus.err} !== {4'b0011, 1'b0, 1'b0}) begin
      $display("FAIL hold: got b=%b out_valid=%b err=%b, want b=0011 out_valid=0 err=0",
               bus.b, bus.out_valid, bus.err);
    end else pass_cnt++;
    bus.a = 10'bxxxxxxxxxx;
    @(negedge clk);
    total_cnt++;
    if ({bus.b, bus.out_valid, bus.err} !== {4'b0011, 1'b0, 1'b0}) begin
      $display("FAIL hold_x: got b=%b out_valid=%b err=%b, want b=0011 out_valid=0 err=0",
               bus.b, bus.out_valid, bus.err);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid_stream();
    // b holds 0011 from the hold test, so a clear to 0000 is observable.
    bus.in_valid = 1'b1;
    bus.a        = 10'b0001000000;
    rst_n        = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({bus.b, bus.out_valid, bus.err} !== {4'b0000, 1'b0, 1'b0}) begin
      $display("FAIL reset_mid: got b=%b out_valid=%b err=%b, want b=0000 out_valid=0 err=0",
               bus.b, bus.out_valid, bus.err);
    end else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({bus.b, bus.out_valid, bus.err} !== {4'b0110, 1'b1, 1'b0}) begin
      $display("FAIL after_reset: got b=%b out_valid=%b err=%b, want b=0110 out_valid=1 err=0",
               bus.b, bus.out_valid, bus.err);
    end else pass_cnt++;
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_walk_one_hot();
    test_zero();
    test_multi_hot();
    test_hold();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
